// File: rtl/charram_write_arbiter.sv
// Character-RAM write-port arbiter: three byte-stream producers each feed a
// small FIFO, a round-robin arbiter drains them into per-channel screen
// regions, and a clear sequence blanks the whole RAM on request.
module charram_write_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [9:0]  BASE0      = 10'd0,
  parameter logic [9:0]  BASE1      = 10'd80,
  parameter logic [9:0]  BASE2      = 10'd120,
  parameter int unsigned LEN0       = 64,
  parameter int unsigned LEN1       = 16,
  parameter int unsigned LEN2       = 16,
  parameter int unsigned CHAR_DEPTH = 600,
  parameter logic [6:0]  CLR_CHAR   = 7'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_req,
  input  logic       ch0_we,
  input  logic [5:0] ch0_addr,
  input  logic [7:0] ch0_data,
  input  logic       ch1_we,
  input  logic [3:0] ch1_addr,
  input  logic [7:0] ch1_data,
  input  logic       ch2_we,
  input  logic [3:0] ch2_addr,
  input  logic [7:0] ch2_data,
  output logic       ram_we,
  output logic [9:0] ram_addr,
  output logic [6:0] ram_data,
  output logic       busy,
  output logic [2:0] ovf
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned NW = (CHAR_DEPTH > 1) ? $clog2(CHAR_DEPTH) : 1;
  localparam int unsigned EW = 17;  // {screen address[9:0], character[6:0]}

  typedef enum logic {ST_ARB, ST_CLEAR} state_e;

  // Incoming strobes, already range-checked, relocated and mapped
  logic [2:0]    in_vld;
  logic [EW-1:0] in_ent [3];

  logic [2:0]    cap_vld_q;
  logic [EW-1:0] cap_ent_q [3];

  logic [EW-1:0] mem_q    [3][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q [3];
  logic [PW-1:0] rd_ptr_q [3];
  logic [CW-1:0] cnt_q    [3];
  logic [2:0]    ovf_q;

  logic [2:0]    full, nonempty, push, pop, ovf_set;
  logic          gnt_vld;
  logic [1:0]    gnt_idx;
  logic [EW-1:0] gnt_ent;
  int unsigned   scan;

  state_e        state_q;
  logic [1:0]    ptr_q;
  logic [NW-1:0] clr_cnt_q;
  logic          ram_we_q;
  logic [9:0]    ram_addr_q;
  logic [6:0]    ram_data_q;
  logic          busy_q;

  // Filter out-of-range addresses, relocate to screen region, map bit-7 bytes to '?'
  always_comb begin
    in_vld[0] = ch0_we && (32'(ch0_addr) < LEN0);
    in_vld[1] = ch1_we && (32'(ch1_addr) < LEN1);
    in_vld[2] = ch2_we && (32'(ch2_addr) < LEN2);
    in_ent[0] = {BASE0 + 10'(ch0_addr), ch0_data[7] ? 7'h3F : ch0_data[6:0]};
    in_ent[1] = {BASE1 + 10'(ch1_addr), ch1_data[7] ? 7'h3F : ch1_data[6:0]};
    in_ent[2] = {BASE2 + 10'(ch2_addr), ch2_data[7] ? 7'h3F : ch2_data[6:0]};
  end

  // Round-robin grant from ptr_q; suspended while clearing or when a clear starts
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    scan    = 0;
    for (int unsigned i = 0; i < 3; i++) begin
      nonempty[i] = (cnt_q[i] != '0);
    end
    if (state_q == ST_ARB && !clr_req) begin
      for (int unsigned k = 0; k < 3; k++) begin
        scan = (32'(ptr_q) + k) % 3;
        if (!gnt_vld && nonempty[2'(scan)]) begin
          gnt_vld = 1'b1;
          gnt_idx = 2'(scan);
        end
      end
    end
    pop = '0;
    if (gnt_vld) pop[gnt_idx] = 1'b1;
  end

  // Push acceptance (a full FIFO still accepts when popped the same cycle) and granted entry
  always_comb begin
    gnt_ent = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      full[i]    = (cnt_q[i] == CW'(FIFO_DEPTH));
      push[i]    = cap_vld_q[i] && (!full[i] || pop[i]);
      ovf_set[i] = cap_vld_q[i] && full[i] && !pop[i];
      if (pop[i]) gnt_ent = mem_q[i][rd_ptr_q[i]];
    end
  end

  // Input capture stage, FIFO pointers/occupancy and sticky overflow flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_vld_q <= '0;
      ovf_q     <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        cap_ent_q[i] <= '0;
        wr_ptr_q[i]  <= '0;
        rd_ptr_q[i]  <= '0;
        cnt_q[i]     <= '0;
      end
    end else begin
      cap_vld_q <= in_vld;
      for (int unsigned i = 0; i < 3; i++) begin
        cap_ent_q[i] <= in_ent[i];
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PW'(1);
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
        case ({push[i], pop[i]})
          2'b10:   cnt_q[i] <= cnt_q[i] + CW'(1);
          2'b01:   cnt_q[i] <= cnt_q[i] - CW'(1);
          default: cnt_q[i] <= cnt_q[i];
        endcase
      end
      // A clear request wins over an overflow landing on the same edge
      if (clr_req) ovf_q <= '0;
      else         ovf_q <= ovf_q | ovf_set;
    end
  end

  // FIFO storage; contents are meaningless until pointed at, so no reset
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 3; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= cap_ent_q[i];
    end
  end

  // Arbitrate/clear FSM with registered RAM write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_ARB;
      ptr_q      <= '0;
      clr_cnt_q  <= '0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      busy_q     <= 1'b0;
    end else if (clr_req) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      ram_we_q  <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        ST_ARB: begin
          ram_we_q <= gnt_vld;
          if (gnt_vld) begin
            ram_addr_q <= gnt_ent[16:7];
            ram_data_q <= gnt_ent[6:0];
            case (gnt_idx)
              2'd0:    ptr_q <= 2'd1;
              2'd1:    ptr_q <= 2'd2;
              default: ptr_q <= 2'd0;
            endcase
          end
        end
        ST_CLEAR: begin
          ram_we_q   <= 1'b1;
          ram_addr_q <= 10'(clr_cnt_q);
          ram_data_q <= CLR_CHAR;
          if (clr_cnt_q == NW'(CHAR_DEPTH - 1)) begin
            state_q   <= ST_ARB;
            busy_q    <= 1'b0;
            clr_cnt_q <= '0;
          end else begin
            clr_cnt_q <= clr_cnt_q + NW'(1);
          end
        end
        default: state_q <= ST_ARB;
      endcase
    end
  end

  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign busy     = busy_q;
  assign ovf      = ovf_q;

endmodule
